// File: rtl/mdu_iter.sv
// mdu_iter: iterative radix-2 multiply/divide unit holding the HI/LO register pair
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [2*WIDTH-1:0] prod, prod_neg;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH:0] rem, rem_nx, sum;
    logic [WIDTH-1:0] opnd, abs_a, abs_b, hi_fix, lo_fix;
    logic is_div, neg_q, neg_r, div0, sgn, ge;

    // next state: MULT/DIV requests leave IDLE, CALC runs WIDTH steps, FIX takes one cycle
    always_comb begin
        state_nx = state;
        if (state == IDLE && start && !op[2]) state_nx = CALC;
        else if (state == CALC && cnt == CW'(WIDTH - 1)) state_nx = FIX;
        else if (state == FIX) state_nx = IDLE;
        busy = state != IDLE;
    end

    // operand magnitudes, one shift-add / restoring step, and the final sign fix-up
    always_comb begin
        sgn      = !op[0];
        abs_a    = (sgn && a[WIDTH-1]) ? -a : a;
        abs_b    = (sgn && b[WIDTH-1]) ? -b : b;
        sum      = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, opnd & {WIDTH{prod[0]}}};
        shifted  = {rem, prod[WIDTH-1]};
        ge       = shifted >= {2'b0, opnd};
        rem_nx   = (WIDTH+1)'(ge ? shifted - {2'b0, opnd} : shifted);
        prod_neg = neg_q ? -prod : prod;
        hi_fix   = is_div ? (neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0]) : prod_neg[2*WIDTH-1:WIDTH];
        lo_fix   = is_div ? ((neg_q && !div0) ? -prod[WIDTH-1:0] : prod[WIDTH-1:0]) : prod_neg[WIDTH-1:0];
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end

    // datapath: operand latch, iteration, HI/LO writes and the done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            cnt    <= '0;
            prod   <= '0;
            rem    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
        end else begin
            done <= state == FIX;
            if (state == IDLE && start) begin
                if (op == 3'd4) hi <= a;
                if (op == 3'd5) lo <= a;
                if (!op[2]) begin
                    is_div <= op[1];
                    neg_q  <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_r  <= sgn && a[WIDTH-1];
                    div0   <= op[1] && b == '0;
                    opnd   <= op[1] ? abs_b : abs_a;
                    prod   <= {{WIDTH{1'b0}}, op[1] ? abs_a : abs_b};
                    rem    <= '0;
                    cnt    <= '0;
                end
            end else if (state == CALC) begin
                cnt  <= cnt + 1'b1;
                prod <= is_div ? {prod[2*WIDTH-1:WIDTH], prod[WIDTH-2:0], ge} : {sum, prod[WIDTH-1:1]};
                if (is_div) rem <= rem_nx;
            end else if (state == FIX) begin
                hi <= hi_fix;
                lo <= lo_fix;
            end
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: randomized and directed checks of mdu_iter at WIDTH=32 and WIDTH=8 against an arithmetic model
module tb_mdu_iter;
    logic clk = 0, reset = 1, start32 = 0, start8 = 0;
    logic [2:0] op = 0;
    logic [31:0] a = 0, b = 0;
    logic [31:0] hi32, lo32;
    logic [7:0] hi8, lo8;
    logic busy32, done32, busy8, done8;
    logic [31:0] mhi [2];
    logic [31:0] mlo [2];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .start(start32), .op(op), .a(a), .b(b),
                                  .hi(hi32), .lo(lo32), .busy(busy32), .done(done32));
    mdu_iter #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .start(start8), .op(op), .a(a[7:0]), .b(b[7:0]),
                                .hi(hi8), .lo(lo8), .busy(busy8), .done(done8));

    function automatic logic [31:0] get_hi(int w); return w == 8 ? {24'b0, hi8} : hi32; endfunction
    function automatic logic [31:0] get_lo(int w); return w == 8 ? {24'b0, lo8} : lo32; endfunction
    function automatic logic get_busy(int w); return w == 8 ? busy8 : busy32; endfunction
    function automatic logic get_done(int w); return w == 8 ? done8 : done32; endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // plain-arithmetic reference for ops 0..3, returns {hi, lo}
    function automatic logic [63:0] ref_op(int w, logic [2:0] o, logic [31:0] x, logic [31:0] y);
        longint unsigned m, ux, uy, h, l, p;
        longint sx, sy;
        m  = (64'd1 << w) - 1;
        ux = {32'b0, x} & m;
        uy = {32'b0, y} & m;
        sx = x[w-1] ? longint'(ux) - longint'(m) - 1 : longint'(ux);
        sy = y[w-1] ? longint'(uy) - longint'(m) - 1 : longint'(uy);
        h = 0;
        l = 0;
        if (o == 0) begin
            p = $unsigned(sx * sy);
            h = (p >> w) & m;
            l = p & m;
        end else if (o == 1) begin
            p = ux * uy;
            h = (p >> w) & m;
            l = p & m;
        end else if (uy == 0) begin
            h = ux;
            l = m;
        end else if (o == 2) begin
            h = $unsigned(sx % sy) & m;
            l = $unsigned(sx / sy) & m;
        end else begin
            h = ux % uy;
            l = ux / uy;
        end
        return {h[31:0], l[31:0]};
    endfunction

    task automatic wait_done(input int w, output int k, output int nb, output logic [31:0] fh, output logic [31:0] fl);
        k = 1;
        nb = 0;
        fh = 0;
        fl = 0;
        while (!get_done(w) && k < w + 8) begin
            if (get_busy(w)) nb++;
            if (k == w + 1) begin
                fh = get_hi(w);
                fl = get_lo(w);
            end
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run(input int w, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input string tag, input bit b2b = 0);
        int s, k, nb;
        logic [31:0] eh, el, fh, fl;
        logic [63:0] r;
        s = (w == 8) ? 1 : 0;
        eh = mhi[s];
        el = mlo[s];
        if (o < 4) begin
            r = ref_op(w, o, x, y);
            eh = r[63:32];
            el = r[31:0];
        end else if (o == 4) eh = (w == 8) ? {24'b0, x[7:0]} : x;
        else if (o == 5) el = (w == 8) ? {24'b0, x[7:0]} : x;
        if (!b2b) @(negedge clk);
        op = o;
        a = x;
        b = y;
        start8 = (w == 8);
        start32 = (w != 8);
        @(negedge clk);
        start8 = 0;
        start32 = 0;
        a = $urandom;
        b = $urandom;
        if (o < 4) begin
            wait_done(w, k, nb, fh, fl);
            check({tag, "_latency"}, 64'(k), 64'(w + 2));
            check({tag, "_busy_cycles"}, 64'(nb), 64'(w + 1));
            check({tag, "_hold"}, {fh, fl}, {mhi[s], mlo[s]});
        end else begin
            check({tag, "_idle"}, {62'b0, get_busy(w), get_done(w)}, 64'd0);
        end
        check({tag, "_hi"}, 64'(get_hi(w)), 64'(eh));
        check({tag, "_lo"}, 64'(get_lo(w)), 64'(el));
        mhi[s] = eh;
        mlo[s] = el;
    endtask

    initial begin
        int k, nb, nd, w;
        logic [2:0] o;
        logic [31:0] x, y, fh, fl;
        mhi[0] = 0; mhi[1] = 0; mlo[0] = 0; mlo[1] = 0;
        repeat (3) @(negedge clk);
        reset = 0;
        check("reset32", {hi32, lo32}, 64'd0);
        check("reset8", {48'b0, hi8, lo8}, 64'd0);
        check("reset_flags", {60'b0, busy32, done32, busy8, done8}, 64'd0);

        run(32, 0, 7, 6, "mult");
        @(negedge clk);
        check("done_pulse", 64'(done32), 64'd0);
        run(32, 0, 32'hFFFF_FFFD, 5, "mult_neg");
        run(32, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run(32, 2, 32'hFFFF_FFF9, 2, "div_neg");
        run(32, 2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run(32, 3, 7, 0, "divu_zero");
        run(32, 2, 32'hFFFF_FFF9, 0, "div_zero");
        run(32, 4, 32'h1234, 0, "mthi");
        run(32, 6, 32'h55, 0, "nop");

        // MTLO held on start while a MULT is in flight must be ignored
        @(negedge clk);
        op = 0; a = 3; b = 5; start32 = 1;
        @(negedge clk);
        op = 5; a = 32'hDEAD;
        @(negedge clk);
        start32 = 0;
        wait_done(32, k, nb, fh, fl);
        check("mtlo_busy_latency", 64'(k), 64'd33);
        check("mtlo_busy_result", {hi32, lo32}, {32'd0, 32'd15});
        mhi[0] = 0;
        mlo[0] = 15;

        run(32, 0, 9, 9, "b2b_first");
        run(32, 1, 12, 13, "b2b_second", 1);
        run(8, 0, 8'hFD, 5, "mult8");
        run(8, 2, 8'hF9, 2, "div8");
        run(8, 2, 8'h80, 8'hFF, "div8_ovf");

        for (int i = 0; i < 60; i++) begin
            w = (i % 2 == 1) ? 8 : 32;
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 7) == 0) y = 0;
            if ($urandom_range(0, 7) == 0) y = 32'hFFFF_FFFF;
            if ($urandom_range(0, 7) == 0) x = (w == 8) ? 32'h80 : 32'h8000_0000;
            run(w, o, x, y, "rnd");
        end

        // reset in the middle of CALC aborts the op without a done pulse
        @(negedge clk);
        op = 0; a = 7; b = 6; start32 = 1;
        @(negedge clk);
        start32 = 0;
        repeat (9) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("abort_regs", {hi32, lo32}, 64'd0);
        check("abort_busy", 64'(busy32), 64'd0);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32) nd++;
        end
        check("abort_no_done", 64'(nd), 64'd0);
        mhi[0] = 0; mhi[1] = 0; mlo[0] = 0; mlo[1] = 0;
        run(32, 0, 32'hFFFF_FFFD, 5, "after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
